// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;

  // Clocks per oversample tick, floored, never below one.
  function automatic int calc_div(input int clock_freq, input int baud);
    int d;
    d = clock_freq / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head.
// Ports:
//   clock, rst      : clock, synchronous active-high reset
//   push, push_data : write request; ignored when full unless popping too
//   pop             : remove head entry; ignored when empty
//   head_data       : registered head entry, holds last value when empty
//   empty, full     : occupancy flags, derived from the count register
// DEPTH must be a power of two, at least 2.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_nxt;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      // Head tracks the entry at the post-update read pointer. With one
      // entry left and a simultaneous push, the new byte is not in mem yet.
      if (do_pop) begin
        if (count > (AW+1)'(1)) head_data <= mem[rd_nxt];
        else if (do_push)       head_data <= push_data;
      end else if (empty && do_push) begin
        head_data <= push_data;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) with a byte FIFO on the consumer side.
// Ports:
//   clock, rst  : clock, synchronous active-high reset
//   rx          : asynchronous serial input, idles high
//   rx_data     : byte at FIFO head
//   rx_valid    : FIFO not empty
//   rx_ready    : consumer takes the head byte when high with rx_valid
//   rx_active   : a frame is being received
//   frame_err   : one-cycle pulse, stop bit sampled low
//   parity_err  : one-cycle pulse, even parity mismatch (UART_RX_PARITY_EN)
//   overrun     : one-cycle pulse, good byte dropped on a full FIFO
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_active,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun
);
  localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Two-flop synchroniser, idle-high after reset so no false start.
  logic rx_m, rxs;
  always_ff @(posedge clock) begin
    if (rst) begin
      rx_m <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_m <= rx;
      rxs  <= rx_m;
    end
  end

  // Free-running 16x baud tick.
  logic [DW-1:0] div_cnt;
  logic          tick;
  assign tick = (div_cnt == DW'(DIV - 1));
  always_ff @(posedge clock) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  rx_state_t            state;
  logic [3:0]           scnt;
  logic [BW-1:0]        bidx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] push_byte;
  logic                 push_q;
  logic                 s_lo, s_mid, maj;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
`endif

  // Two stored samples plus the live one at SAMPLE_HI.
  assign maj = (s_lo & s_mid) | (s_lo & rxs) | (s_mid & rxs);

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      bidx      <= '0;
      shift     <= '0;
      push_byte <= '0;
      push_q    <= 1'b0;
      s_lo      <= 1'b1;
      s_mid     <= 1'b1;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      push_q    <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (tick) begin
        case (state)
          IDLE:  if (!rxs) begin
                   state <= START;
                   scnt  <= '0;
                 end
          BREAK: if (rxs) state <= IDLE;
          default: begin
            scnt <= scnt + 4'd1;
            if (scnt == 4'(SAMPLE_LO))  s_lo  <= rxs;
            if (scnt == 4'(SAMPLE_MID)) s_mid <= rxs;
            if (scnt == 4'(SAMPLE_HI)) begin
              case (state)
                START: if (!maj) begin
                         state <= DATA;
                         bidx  <= '0;
                       end else begin
                         state <= IDLE;
                       end
                DATA: begin
                  shift <= {maj, shift[DATA_BITS-1:1]};
                  if (bidx == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state <= PARITY;
`else
                    state <= STOP;
`endif
                  end else begin
                    bidx <= bidx + BW'(1);
                  end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                  par_bad    <= ^{shift, maj};
                  parity_err <= ^{shift, maj};
                  state      <= STOP;
                end
`endif
                STOP: if (maj) begin
                        // Return to IDLE mid stop bit so a start edge right
                        // after it is still caught.
`ifdef UART_RX_PARITY_EN
                        push_q <= ~par_bad;
`else
                        push_q <= 1'b1;
`endif
                        push_byte <= shift;
                        state     <= IDLE;
                      end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                      end
                default: state <= IDLE;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign rx_active = (state != IDLE);

  logic empty, full, pop;
  assign rx_valid = ~empty;
  assign pop      = rx_valid & rx_ready;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_byte),
    .pop       (pop),
    .head_data (rx_data),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clock) begin
    if (rst) overrun <= 1'b0;
    else     overrun <= push_q & full & ~pop;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo at 16 clocks per bit. Frames are driven bit by bit;
// a queue model of the byte FIFO predicts accepted bytes and overruns.
module tb_uart_rx_fifo;
  logic       clock = 1'b0;
  logic       rst = 1'b1, rx = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, frame_err, overrun;

  always #5 clock = ~clock;

  uart_rx_fifo #(
    .CLOCK_FREQ (16000000),
    .BAUD_RATE  (1000000),
    .DATA_BITS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_active (rx_active),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int total = 0, bad = 0;
  int exp_ferr = 0, exp_ovr = 0, cmp_idx = 0;
  int n_ferr = 0, n_ovr = 0, n_vld = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  // Observer: pulse counters and popped bytes.
  always @(negedge clock) begin
    if (!rst) begin
      if (frame_err) n_ferr++;
      if (overrun)   n_ovr++;
      if (rx_valid)  n_vld++;
      if (rx_valid && rx_ready) obs_q.push_back(rx_data);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      rx = 1'b1;
    end
  endtask

  // Drive one frame. noise flips rx for one cycle at that frame cycle;
  // abort_at asserts rst at that frame cycle and stops driving.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int noise, input int abort_at);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int c = 0; c < 160; c++) begin
      @(negedge clock);
      if (c == abort_at) begin
        rst = 1'b1;
        rx  = 1'b1;
        break;
      end
      rx = fr[c/16] ^ (c == noise);
      if (c == 144) begin
        if (!stop_ok)                            exp_ferr++;
        else if (exp_q.size() - obs_q.size() < 4) exp_q.push_back(b);
        else                                     exp_ovr++;
      end
    end
  endtask

  task automatic drain_check();
    for (int i = cmp_idx; i < obs_q.size() && i < exp_q.size(); i++)
      chk("pop_data", obs_q[i], exp_q[i]);
    chk("pop_count", obs_q.size(), exp_q.size());
    cmp_idx = obs_q.size();
  endtask

  initial begin
    int v0, f0, o0;
    logic [7:0] b;

    repeat (3) @(negedge clock);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_active", rx_active, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    idle(20);

    // single frame, consumer always ready
    rx_ready = 1'b1;
    v0 = n_vld; f0 = n_ferr; o0 = n_ovr;
    send(8'hA5, 1, -1, -1);
    idle(20);
    chk("t1_vld_cycles", n_vld - v0, 1);
    chk("t1_ferr", n_ferr - f0, 0);
    chk("t1_ovr", n_ovr - o0, 0);
    drain_check();

    // back-to-back frames held in the FIFO
    rx_ready = 1'b0;
    send(8'h00, 1, -1, -1);
    send(8'hFF, 1, -1, -1);
    send(8'h55, 1, -1, -1);
    idle(10);
    chk("t2_valid", rx_valid, 1);
    chk("t2_head", rx_data, exp_q[cmp_idx]);
    rx_ready = 1'b1;
    idle(10);
    chk("t2_empty", rx_valid, 0);
    drain_check();

    // overrun on the fifth byte
    rx_ready = 1'b0;
    o0 = n_ovr;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send(b, 1, -1, -1);
    end
    idle(10);
    chk("t3_ovr", n_ovr - o0, 1);
    chk("t3_ovr_model", n_ovr, exp_ovr);
    rx_ready = 1'b1;
    idle(10);
    drain_check();

    // start glitch
    f0 = n_ferr;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      rx = 1'b0;
    end
    @(negedge clock);
    rx = 1'b1;
    chk("t4_active_hi", rx_active, 1);
    idle(40);
    chk("t4_active_lo", rx_active, 0);
    chk("t4_valid", rx_valid, 0);
    chk("t4_ferr", n_ferr - f0, 0);
    drain_check();

    // bad stop bit, line held low, then a good frame
    f0 = n_ferr;
    b = 8'($urandom);
    send(b, 0, -1, -1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      rx = 1'b0;
    end
    idle(20);
    chk("t5_ferr", n_ferr - f0, 1);
    chk("t5_valid", rx_valid, 0);
    send(8'h3C, 1, -1, -1);
    idle(20);
    chk("t5_ferr_after", n_ferr - f0, 1);
    drain_check();

    // noise on data bit 0 mid sample, then reset mid-frame
    send(8'h01, 1, 25, -1);
    idle(20);
    drain_check();
    rx_ready = 1'b0;
    b = 8'($urandom);
    send(b, 1, -1, -1);
    idle(5);
    chk("t6_pre_valid", rx_valid, 1);
    b = 8'($urandom);
    send(b, 1, -1, 88);
    repeat (3) @(negedge clock);
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_active", rx_active, 0);
    chk("t6_rst_data", rx_data, 0);
    while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
    rst = 1'b0;
    idle(30);
    chk("t6_post_valid", rx_valid, 0);
    chk("t6_post_active", rx_active, 0);

    // random frames, gaps and mid-sample noise
    rx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      send(b, 1, ($urandom_range(0, 1) != 0) ? 16 * $urandom_range(1, 8) + 9 : -1, -1);
      idle($urandom_range(0, 20));
    end
    idle(50);
    drain_check();
    chk("ovr_total", n_ovr, exp_ovr);
    chk("ferr_total", n_ferr, exp_ferr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
